// File: rtl/knn_ctrl.sv
// Sequencer around the combinational KNN distance core: streams training points
// from the point RAM and keeps a stable, sorted list of the K nearest neighbours.
module knn_ctrl #(
  parameter int DATA_W  = 32,
  parameter int K       = 4,
  parameter int N_W     = 8,
  parameter int LABEL_W = 8,
  localparam int CNT_W  = $clog2(K + 1),
  localparam int SEL_W  = (K > 1) ? $clog2(K) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_W-1:0]      n_points,
  input  logic [DATA_W-1:0]   test_x,
  input  logic [DATA_W-1:0]   test_y,
  output logic                busy,
  output logic                done,
  output logic                mem_en,
  output logic [N_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]   mem_x,
  input  logic [DATA_W-1:0]   mem_y,
  input  logic [LABEL_W-1:0]  mem_label,
  output logic [DATA_W-1:0]   core_x1,
  output logic [DATA_W-1:0]   core_y1,
  output logic [DATA_W-1:0]   core_x2,
  output logic [DATA_W-1:0]   core_y2,
  input  logic [2*DATA_W-1:0] core_z,
  input  logic [SEL_W-1:0]    nb_sel,
  output logic [2*DATA_W-1:0] nb_dist,
  output logic [LABEL_W-1:0]  nb_label,
  output logic [CNT_W-1:0]    nb_count
);

  localparam logic [CNT_W-1:0] K_C = CNT_W'(K);

  typedef enum logic [2:0] {IDLE, READ, WAIT, INSERT, DONE} state_t;

  state_t               state;
  logic [DATA_W-1:0]    tx_q;
  logic [DATA_W-1:0]    ty_q;
  logic [N_W-1:0]       n_q;
  logic [N_W-1:0]       idx;
  logic [2*DATA_W-1:0]  dist_r;
  logic [LABEL_W-1:0]   lab_r;
  logic [2*DATA_W-1:0]  dist_q   [K];
  logic [LABEL_W-1:0]   lab_q    [K];
  logic [2*DATA_W-1:0]  nxt_dist [K];
  logic [LABEL_W-1:0]   nxt_lab  [K];
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     pos;

  assign core_x1  = tx_q;
  assign core_y1  = ty_q;
  assign core_x2  = mem_x;
  assign core_y2  = mem_y;
  assign nb_count = cnt_q;

  // Insertion position: equal distances land behind existing entries (stable).
  always_comb begin
    pos = '0;
    for (int i = 0; i < K; i++) begin
      if (CNT_W'(i) < cnt_q && dist_q[i] <= dist_r) pos = pos + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < K; i++) begin
      nxt_dist[i] = dist_q[i];
      nxt_lab[i]  = lab_q[i];
      if (CNT_W'(i) == pos) begin
        nxt_dist[i] = dist_r;
        nxt_lab[i]  = lab_r;
      end else if (CNT_W'(i) > pos) begin
        nxt_dist[i] = dist_q[(i > 0) ? i - 1 : 0];
        nxt_lab[i]  = lab_q[(i > 0) ? i - 1 : 0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      tx_q     <= '0;
      ty_q     <= '0;
      n_q      <= '0;
      idx      <= '0;
      dist_r   <= '0;
      lab_r    <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < K; i++) begin
        dist_q[i] <= '1;
        lab_q[i]  <= '0;
      end
    end else begin
      done   <= 1'b0;
      mem_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_q  <= test_x;
            ty_q  <= test_y;
            n_q   <= n_points;
            idx   <= '0;
            cnt_q <= '0;
            busy  <= 1'b1;
            for (int i = 0; i < K; i++) begin
              dist_q[i] <= '1;
              lab_q[i]  <= '0;
            end
            if (n_points == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= READ;
              mem_en   <= 1'b1;
              mem_addr <= '0;
            end
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          dist_r <= core_z;
          lab_r  <= mem_label;
          state  <= INSERT;
        end
        INSERT: begin
          if (pos < K_C) begin
            for (int i = 0; i < K; i++) begin
              dist_q[i] <= nxt_dist[i];
              lab_q[i]  <= nxt_lab[i];
            end
            if (cnt_q < K_C) cnt_q <= cnt_q + 1'b1;
          end
          idx <= idx + 1'b1;
          if (idx == n_q - 1'b1) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= READ;
            mem_en   <= 1'b1;
            mem_addr <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Slots past the valid count always read as empty, whatever they hold.
  always_comb begin
    nb_dist  = '1;
    nb_label = '0;
    if (int'(nb_sel) < K && int'(nb_sel) < int'(cnt_q)) begin
      nb_dist  = dist_q[nb_sel];
      nb_label = lab_q[nb_sel];
    end
  end

endmodule

// File: tb/tb_knn_ctrl.sv
// Self-checking bench for knn_ctrl: RAM and distance-core models plus a
// sort-by-selection reference of the K nearest points.
module tb_knn_ctrl;
  localparam int DATA_W  = 32;
  localparam int K       = 4;
  localparam int N_W     = 8;
  localparam int LABEL_W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [N_W-1:0]      n_points;
  logic [DATA_W-1:0]   test_x;
  logic [DATA_W-1:0]   test_y;
  logic                busy;
  logic                done;
  logic                mem_en;
  logic [N_W-1:0]      mem_addr;
  logic [DATA_W-1:0]   mem_x;
  logic [DATA_W-1:0]   mem_y;
  logic [LABEL_W-1:0]  mem_label;
  logic [DATA_W-1:0]   core_x1;
  logic [DATA_W-1:0]   core_y1;
  logic [DATA_W-1:0]   core_x2;
  logic [DATA_W-1:0]   core_y2;
  logic [2*DATA_W-1:0] core_z;
  logic [1:0]          nb_sel;
  logic [2*DATA_W-1:0] nb_dist;
  logic [LABEL_W-1:0]  nb_label;
  logic [2:0]          nb_count;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0]   ram_x [256];
  logic [DATA_W-1:0]   ram_y [256];
  logic [LABEL_W-1:0]  ram_l [256];

  logic [2*DATA_W-1:0] exp_dist [K];
  logic [LABEL_W-1:0]  exp_lab  [K];
  int                  exp_cnt;
  logic [2*DATA_W-1:0] got_dist [K];
  logic [LABEL_W-1:0]  got_lab  [K];
  int                  got_cnt;

  int done_cycle, done_pulses, mem_reads, busy_err;

  knn_ctrl #(.DATA_W(DATA_W), .K(K), .N_W(N_W), .LABEL_W(LABEL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n_points(n_points),
    .test_x(test_x), .test_y(test_y), .busy(busy), .done(done),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_x(mem_x), .mem_y(mem_y),
    .mem_label(mem_label), .core_x1(core_x1), .core_y1(core_y1),
    .core_x2(core_x2), .core_y2(core_y2), .core_z(core_z),
    .nb_sel(nb_sel), .nb_dist(nb_dist), .nb_label(nb_label),
    .nb_count(nb_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] sqd(input logic [31:0] ax, input logic [31:0] ay,
                                      input logic [31:0] bx, input logic [31:0] by);
    longint dx, dy;
    dx = longint'($signed(ax)) - longint'($signed(bx));
    dy = longint'($signed(ay)) - longint'($signed(by));
    return 64'(dx * dx + dy * dy);
  endfunction

  always_comb core_z = sqd(core_x1, core_y1, core_x2, core_y2);

  // Synchronous-read point RAM.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_x     <= ram_x[mem_addr];
      mem_y     <= ram_y[mem_addr];
      mem_label <= ram_l[mem_addr];
    end
  end

  task automatic load_pt(input int i, input int x, input int y, input int l);
    ram_x[i] = 32'(x);
    ram_y[i] = 32'(y);
    ram_l[i] = 8'(l);
  endtask

  // Reference: repeatedly pick the smallest distance, lowest index first on ties.
  task automatic model_compute(input int n, input int tx, input int ty);
    logic [63:0] d [256];
    bit used [256];
    int best;
    for (int j = 0; j < n; j++) begin
      d[j] = sqd(32'(tx), 32'(ty), ram_x[j], ram_y[j]);
      used[j] = 0;
    end
    exp_cnt = (n < K) ? n : K;
    for (int s = 0; s < K; s++) begin
      exp_dist[s] = '1;
      exp_lab[s]  = '0;
      if (s < exp_cnt) begin
        best = -1;
        for (int j = 0; j < n; j++)
          if (!used[j] && (best < 0 || d[j] < d[best])) best = j;
        used[best]  = 1;
        exp_dist[s] = d[best];
        exp_lab[s]  = ram_l[best];
      end
    end
  endtask

  task automatic run_search(input int n, input int tx, input int ty, input logic [63:0] pulse_mask);
    @(negedge clk);
    start = 1'b1;
    n_points = N_W'(n);
    test_x = 32'(tx);
    test_y = 32'(ty);
    @(negedge clk);
    done_cycle = -1; done_pulses = 0; mem_reads = 0; busy_err = 0;
    for (int c = 1; c <= 3 * n + 3; c++) begin
      start = pulse_mask[c];
      if (done) begin
        done_pulses++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (mem_en) mem_reads++;
      if (busy !== (c <= 3 * n + 1)) busy_err++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic read_list();
    for (int i = 0; i < K; i++) begin
      nb_sel = 2'(i);
      #1;
      got_dist[i] = nb_dist;
      got_lab[i]  = nb_label;
    end
    got_cnt = int'(nb_count);
    nb_sel = 2'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; n_points = '0; test_x = '0; test_y = '0; nb_sel = '0;
    #12;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_en !== 1'b0 || mem_addr !== '0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: busy=%b done=%b mem_en=%b mem_addr=%0d, want 0 0 0 0", busy, done, mem_en, mem_addr);
    end
    total++;
    if (nb_count !== 3'd0 || nb_dist !== '1 || nb_label !== '0 || core_x1 !== '0 || core_y1 !== '0) begin
      bad++;
      $display("[TB] FAIL reset_list: cnt=%0d dist=%h label=%0d x1=%h y1=%h, want 0 all-ones 0 0 0", nb_count, nb_dist, nb_label, core_x1, core_y1);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero_points();
    run_search(0, 0, 0, 64'd0);
    total++;
    if (done_cycle !== 1 || done_pulses !== 1) begin
      bad++;
      $display("[TB] FAIL zero_done: cycle=%0d pulses=%0d, want 1 1", done_cycle, done_pulses);
    end
    total++;
    if (busy_err !== 0 || mem_reads !== 0 || nb_count !== 3'd0) begin
      bad++;
      $display("[TB] FAIL zero_misc: busy_err=%0d reads=%0d cnt=%0d, want 0 0 0", busy_err, mem_reads, nb_count);
    end
  endtask

  task automatic check_search(input string name, input int n, input int tx, input int ty, input logic [63:0] mask);
    model_compute(n, tx, ty);
    run_search(n, tx, ty, mask);
    read_list();
    total++;
    if (done_cycle !== 3 * n + 1 || done_pulses !== 1) begin
      bad++;
      $display("[TB] FAIL %s_done: cycle=%0d pulses=%0d, want %0d 1", name, done_cycle, done_pulses, 3 * n + 1);
    end
    total++;
    if (mem_reads !== n || busy_err !== 0) begin
      bad++;
      $display("[TB] FAIL %s_seq: reads=%0d busy_err=%0d, want %0d 0", name, mem_reads, busy_err, n);
    end
    total++;
    if (got_cnt !== exp_cnt) begin
      bad++;
      $display("[TB] FAIL %s_count: got %0d want %0d", name, got_cnt, exp_cnt);
    end
    for (int i = 0; i < K; i++) begin
      total++;
      if (got_dist[i] !== exp_dist[i] || got_lab[i] !== exp_lab[i]) begin
        bad++;
        $display("[TB] FAIL %s_entry%0d: got (%0d,L%0d) want (%0d,L%0d)", name, i, got_dist[i], got_lab[i], exp_dist[i], exp_lab[i]);
      end
    end
  endtask

  task automatic load_example();
    load_pt(0, 3, 4, 1); load_pt(1, 1, 1, 2); load_pt(2, 0, 2, 3);
    load_pt(3, 10, 0, 4); load_pt(4, 1, 0, 5);
  endtask

  task automatic test_example();
    load_example();
    check_search("example", 5, 0, 0, 64'd0);
    total++;
    if (got_dist[0] !== 64'd1 || got_lab[0] !== 8'd5 || got_dist[3] !== 64'd25 || got_lab[3] !== 8'd1) begin
      bad++;
      $display("[TB] FAIL example_const: e0=(%0d,L%0d) e3=(%0d,L%0d), want (1,L5) (25,L1)", got_dist[0], got_lab[0], got_dist[3], got_lab[3]);
    end
  endtask

  task automatic test_ties();
    load_pt(0, 2, 2, 1); load_pt(1, -2, 2, 2); load_pt(2, 2, -2, 3);
    load_pt(3, -2, -2, 4); load_pt(4, 2, 2, 5); load_pt(5, -2, -2, 6);
    check_search("ties", 6, 0, 0, 64'd0);
    total++;
    if (got_lab[0] !== 8'd1 || got_lab[1] !== 8'd2 || got_lab[2] !== 8'd3 || got_lab[3] !== 8'd4) begin
      bad++;
      $display("[TB] FAIL ties_order: labels %0d %0d %0d %0d, want 1 2 3 4", got_lab[0], got_lab[1], got_lab[2], got_lab[3]);
    end
  endtask

  task automatic test_negative();
    load_pt(0, 5, 5, 9);
    check_search("negative", 1, -5, -5, 64'd0);
    total++;
    if (got_dist[0] !== 64'd200 || got_lab[0] !== 8'd9 || got_dist[1] !== '1 || got_lab[1] !== 8'd0) begin
      bad++;
      $display("[TB] FAIL negative_const: e0=(%0d,L%0d) e1=(%h,L%0d), want (200,L9) (all-ones,L0)", got_dist[0], got_lab[0], got_dist[1], got_lab[1]);
    end
  endtask

  task automatic test_start_ignored();
    logic [63:0] mask;
    mask = '0;
    mask[2] = 1'b1; mask[5] = 1'b1; mask[9] = 1'b1;
    load_example();
    check_search("restart", 5, 0, 0, mask);
  endtask

  task automatic test_reset_abort();
    load_example();
    @(negedge clk);
    start = 1'b1; n_points = 8'd5; test_x = '0; test_y = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || mem_en !== 1'b0 || nb_count !== 3'd0 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_state: busy=%b mem_en=%b cnt=%0d done=%b, want 0 0 0 0", busy, mem_en, nb_count, done);
    end
    @(negedge clk);
    rst = 1'b0;
    check_search("after_abort", 5, 0, 0, 64'd0);
  endtask

  task automatic test_random();
    int n, tx, ty;
    for (int r = 0; r < 4; r++) begin
      n  = int'($urandom_range(1, 20));
      tx = int'($urandom_range(0, 200)) - 100;
      ty = int'($urandom_range(0, 200)) - 100;
      for (int j = 0; j < n; j++)
        load_pt(j, int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 40)) - 20,
                int'($urandom_range(0, 255)));
      check_search("random", n, tx, ty, 64'd0);
    end
  endtask

  initial begin
    test_reset();
    test_zero_points();
    test_example();
    test_ties();
    test_negative();
    test_start_ignored();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
